// File: rtl/reg_file_8x32_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_8x32_if
// Description : Bus bundle for the 8-entry register bank. Carries the write
//               port, the synchronous clear, both read ports and the
//               status outputs (written flags, write-commit count).
//               master : the block driving writes/read addresses
//               slave  : the register bank itself
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_8x32_if #(
    parameter int DATA_W = 32
);
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [7:0]        written;
    logic [3:0]        wr_count;

    modport master (
        output wr_en, wr_addr, wr_data, clr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, written, wr_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, written, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_8x32.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_8x32
// Description : Eight-entry register bank, one write port, two combinational
//               read ports. Synchronous whole-bank clear (wins over a write
//               on the same edge), per-entry written flags, saturating
//               write-commit counter and optional same-cycle write bypass.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - reg_file_8x32_if.slave (write port, clear, read
//                       ports, written flags, wr_count)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_8x32 #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    reg_file_8x32_if.slave    bus
);

    localparam int         c_NUM_REGS  = 8;
    localparam logic [3:0] c_COUNT_MAX = 4'd15;

    logic [DATA_W-1:0] regs_q [c_NUM_REGS];
    logic [DATA_W-1:0] regs_d [c_NUM_REGS];
    logic [7:0]        written_q;
    logic [7:0]        written_d;
    logic [3:0]        wr_count_q;
    logic [3:0]        wr_count_d;

    logic [7:0]        w_wr_dec;
    logic              w_commit;
    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    // One-hot write decoder; only meaningful when a commit happens.
    always_comb begin
        w_wr_dec = 8'h00;
        case (bus.wr_addr)
            3'd0:    w_wr_dec = 8'h01;
            3'd1:    w_wr_dec = 8'h02;
            3'd2:    w_wr_dec = 8'h04;
            3'd3:    w_wr_dec = 8'h08;
            3'd4:    w_wr_dec = 8'h10;
            3'd5:    w_wr_dec = 8'h20;
            3'd6:    w_wr_dec = 8'h40;
            3'd7:    w_wr_dec = 8'h80;
            default: w_wr_dec = 8'h00;
        endcase
    end

    // A write only commits when no clear is pending on the same edge.
    assign w_commit = bus.wr_en & ~bus.clr;

    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        written_d  = written_q;
        wr_count_d = wr_count_q;

        if (bus.clr) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
            written_d  = 8'h00;
            wr_count_d = 4'd0;
        end else if (w_commit) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (w_wr_dec[i]) begin
                    regs_d[i] = bus.wr_data;
                end
            end
            written_d = written_q | w_wr_dec;
            if (wr_count_q != c_COUNT_MAX) begin
                wr_count_d = wr_count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            written_q  <= 8'h00;
            wr_count_q <= 4'd0;
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            written_q  <= written_d;
            wr_count_q <= wr_count_d;
        end
    end

    // 8-to-1 read mux; every select value is decoded so no X can leak out.
    function automatic logic [DATA_W-1:0] read_mux(input logic [2:0] sel);
        logic [DATA_W-1:0] v;
        v = '0;
        case (sel)
            3'd0:    v = regs_q[0];
            3'd1:    v = regs_q[1];
            3'd2:    v = regs_q[2];
            3'd3:    v = regs_q[3];
            3'd4:    v = regs_q[4];
            3'd5:    v = regs_q[5];
            3'd6:    v = regs_q[6];
            3'd7:    v = regs_q[7];
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_stored_a = read_mux(bus.rd_addr_a);
    assign w_stored_b = read_mux(bus.rd_addr_b);

    generate
        if (BYPASS) begin : g_bypass
            // Forward the in-flight write to any port reading the same entry;
            // a clear on this edge suppresses forwarding.
            assign bus.rd_data_a = (w_commit && (bus.rd_addr_a == bus.wr_addr))
                                   ? bus.wr_data : w_stored_a;
            assign bus.rd_data_b = (w_commit && (bus.rd_addr_b == bus.wr_addr))
                                   ? bus.wr_data : w_stored_b;
        end else begin : g_no_bypass
            assign bus.rd_data_a = w_stored_a;
            assign bus.rd_data_b = w_stored_b;
        end
    endgenerate

    assign bus.written  = written_q;
    assign bus.wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_8x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_8x32
// Description : Self-checking bench for reg_file_8x32. Two instances share
//               the same stimulus, one without bypass and one with bypass,
//               and are compared against a behavioural array model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_file_8x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;

    always #5 clk = ~clk;

    reg_file_8x32_if #(.DATA_W(32)) bus0 ();
    reg_file_8x32_if #(.DATA_W(32)) bus1 ();

    assign bus0.wr_en     = wr_en;
    assign bus0.wr_addr   = wr_addr;
    assign bus0.wr_data   = wr_data;
    assign bus0.clr       = clr;
    assign bus0.rd_addr_a = rd_addr_a;
    assign bus0.rd_addr_b = rd_addr_b;
    assign bus1.wr_en     = wr_en;
    assign bus1.wr_addr   = wr_addr;
    assign bus1.wr_data   = wr_data;
    assign bus1.clr       = clr;
    assign bus1.rd_addr_a = rd_addr_a;
    assign bus1.rd_addr_b = rd_addr_b;

    reg_file_8x32 #(.DATA_W(32), .BYPASS(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    reg_file_8x32 #(.DATA_W(32), .BYPASS(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents, written flags, commit count.
    logic [31:0] m_regs [8];
    logic [7:0]  m_wr;
    int          m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        m_wr  = 8'h00;
        m_cnt = 0;
    endtask

    // Expected read value for a port given the bypass setting.
    function automatic logic [31:0] exp_rd(input logic [2:0] a, input bit byp);
        if (byp && wr_en && !clr && (a == wr_addr)) return wr_data;
        return m_regs[a];
    endfunction

    // Advance one clock edge, apply the edge to the model, release 1ns later.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            if (clr) begin
                model_reset();
            end else if (wr_en) begin
                m_regs[wr_addr] = wr_data;
                m_wr[wr_addr]   = 1'b1;
                if (m_cnt < 15) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'h0; clr = 1'b0;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus0.wr_count !== 4'd0 || bus0.written !== 8'h00 || bus0.rd_data_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_init: cnt=%0d written=%h rd_a=%h required 0/00/0",
                     bus0.wr_count, bus0.written, bus0.rd_data_a);
        end
        // Preload nonzero values.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = $urandom | 32'h1;
            step();
        end
        wr_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd5;
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus0.rd_data_a !== 32'h0 || bus0.rd_data_b !== 32'h0 ||
            bus1.rd_data_a !== 32'h0 || bus1.rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_rd: %h %h %h %h required all 0",
                     bus0.rd_data_a, bus0.rd_data_b, bus1.rd_data_a, bus1.rd_data_b);
        end
        checks++;
        if (bus0.written !== 8'h00 || bus0.wr_count !== 4'd0 ||
            bus1.written !== 8'h00 || bus1.wr_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_async_status: written=%h/%h cnt=%0d/%0d required 00/0",
                     bus0.written, bus1.written, bus0.wr_count, bus1.wr_count);
        end
        // A write presented while reset is held must be discarded.
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hCAFE_F00D;
        step();
        wr_en = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (bus0.rd_data_a !== 32'h0 || bus0.written !== 8'h00 || bus0.wr_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_write_drop: rd_a=%h written=%h cnt=%0d required 0/00/0",
                     bus0.rd_data_a, bus0.written, bus0.wr_count);
        end
    endtask

    task automatic test_write_read_all();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 32'h1000_0000 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            checks++;
            if (bus0.rd_data_a !== 32'h1000_0000 + 32'(i) ||
                bus0.rd_data_b !== 32'h1000_0000 + 32'(7 - i) ||
                bus1.rd_data_a !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL wr_all_read[%0d]: a=%h b=%h a1=%h required %h %h",
                         i, bus0.rd_data_a, bus0.rd_data_b, bus1.rd_data_a,
                         32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(7 - i));
            end
        end
        checks++;
        if (bus0.written !== 8'hFF || bus0.wr_count !== 4'd8) begin
            errors++;
            $display("FAIL wr_all_status: written=%h cnt=%0d required FF/8",
                     bus0.written, bus0.wr_count);
        end
    endtask

    task automatic test_latency_bypass();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD_BEEF;
        rd_addr_a = 3'd3; rd_addr_b = 3'd4;
        #1;
        checks++;
        if (bus0.rd_data_a !== 32'h1000_0003) begin
            errors++;
            $display("FAIL latency_same_cycle: rd_a=%h required %h", bus0.rd_data_a, 32'h1000_0003);
        end
        checks++;
        if (bus1.rd_data_a !== 32'hDEAD_BEEF || bus1.rd_data_b !== 32'h1000_0004) begin
            errors++;
            $display("FAIL bypass_same_cycle: rd_a=%h rd_b=%h required DEADBEEF 10000004",
                     bus1.rd_data_a, bus1.rd_data_b);
        end
        step();
        wr_en = 1'b0;
        #1;
        checks++;
        if (bus0.rd_data_a !== 32'hDEAD_BEEF || bus1.rd_data_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL latency_next_cycle: rd_a=%h/%h required DEADBEEF",
                     bus0.rd_data_a, bus1.rd_data_a);
        end
    endtask

    task automatic test_clear_priority();
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h1234_5678;
        rd_addr_a = 3'd5;
        #1;
        checks++;
        if (bus1.rd_data_a !== 32'h1000_0005) begin
            errors++;
            $display("FAIL clr_no_bypass: rd_a=%h required %h", bus1.rd_data_a, 32'h1000_0005);
        end
        step();
        clr = 1'b0; wr_en = 1'b0;
        #1;
        checks++;
        if (bus0.rd_data_a !== 32'h0 || bus0.written !== 8'h00 || bus0.wr_count !== 4'd0 ||
            bus1.rd_data_a !== 32'h0) begin
            errors++;
            $display("FAIL clr_priority: rd_a=%h written=%h cnt=%0d required 0/00/0",
                     bus0.rd_data_a, bus0.written, bus0.wr_count);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] last;
        last = 32'h0;
        rd_addr_a = 3'd7; rd_addr_b = 3'd0;
        for (int k = 1; k <= 20; k++) begin
            last = $urandom;
            wr_en = 1'b1; wr_addr = 3'd7; wr_data = last;
            step();
            if (k == 14 || k == 15 || k == 16) begin
                checks++;
                if (bus0.wr_count !== 4'((k > 15) ? 15 : k)) begin
                    errors++;
                    $display("FAIL sat_count[%0d]: cnt=%0d required %0d",
                             k, bus0.wr_count, (k > 15) ? 15 : k);
                end
            end
        end
        wr_en = 1'b0;
        #1;
        checks++;
        if (bus0.wr_count !== 4'd15 || bus0.rd_data_a !== last || bus0.written !== 8'h80) begin
            errors++;
            $display("FAIL saturation: cnt=%0d rd7=%h written=%h required 15 %h 80",
                     bus0.wr_count, bus0.rd_data_a, bus0.written, last);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = $urandom;
            clr       = ($urandom_range(0, 31) == 0);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (bus0.rd_data_a !== exp_rd(rd_addr_a, 1'b0) ||
                bus0.rd_data_b !== exp_rd(rd_addr_b, 1'b0) ||
                bus1.rd_data_a !== exp_rd(rd_addr_a, 1'b1) ||
                bus1.rd_data_b !== exp_rd(rd_addr_b, 1'b1) ||
                bus0.written   !== m_wr || bus1.written !== m_wr ||
                bus0.wr_count  !== 4'(m_cnt) || bus1.wr_count !== 4'(m_cnt)) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: a0=%h b0=%h a1=%h b1=%h wr=%h cnt=%0d required a0=%h b0=%h a1=%h b1=%h wr=%h cnt=%0d",
                             n, bus0.rd_data_a, bus0.rd_data_b, bus1.rd_data_a, bus1.rd_data_b,
                             bus0.written, bus0.wr_count,
                             exp_rd(rd_addr_a, 1'b0), exp_rd(rd_addr_b, 1'b0),
                             exp_rd(rd_addr_a, 1'b1), exp_rd(rd_addr_b, 1'b1), m_wr, m_cnt);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read_all();
        test_latency_bypass();
        test_clear_priority();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_8x32.md
Name: reg_file_8x32

Overview:
- Eight-entry, 32-bit register bank with one write port and two read ports.
- Storage is eight 32-bit registers, loaded through a 3-to-8 write decoder.
- Each read port selects one of the eight register outputs through its own 8-to-1 32-bit read multiplexer.
- Adds a synchronous bank clear, per-entry written flags and optional write-to-read bypass. This is the storage and write stage that directly feeds the read-port multiplexers in the register-file datapath.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- BYPASS, 0, 1 = a same-cycle write to the read address forwards wr_data to that read port; 0 = reads always show stored contents.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write enable, sampled on the rising edge of clk.
- wr_addr  input  3  register index to write.
- wr_data  input  DATA_W  write data.
- clr  input  1  synchronous clear of the whole bank.
- rd_addr_a  input  3  read port A index.
- rd_addr_b  input  3  read port B index.
- rd_data_a  output  DATA_W  read port A data; combinational.
- rd_data_b  output  DATA_W  read port B data; combinational.
- written  output  8  bit i = 1 when register i has been written since the last reset or clr.
- wr_count  output  4  number of write commits since the last reset or clr; saturates at 15.

Behaviour:
- Reset (asynchronous, reset=1): registers 0..7 = 0, written = 8'h00, wr_count = 0. With no bypass active, rd_data_a and rd_data_b therefore read 0. Reset is effective immediately, including mid-write; a write on the edge where reset is asserted is discarded.
- Write commit:
  - On the rising edge of clk with reset=0, clr=0 and wr_en=1: reg[wr_addr] <= wr_data, written[wr_addr] <= 1, wr_count <= wr_count+1 (held at 15 when already 15).
  - Write latency is 1 cycle: the new value appears on a read port in the cycle after the edge.
- Decoder: exactly one register is loaded per commit. When wr_en=0 no register, flag or count changes.
- Clear:
  - On the rising edge with clr=1: all registers = 0, written = 0, wr_count = 0.
  - clr has priority over wr_en on the same edge; the write is dropped.
- Read:
  - rd_data_x = reg[rd_addr_x], combinational, zero cycles.
  - Both ports are independent; both may select the same register, and both then show the same value.
- Bypass with BYPASS=1:
  - When wr_en=1, clr=0 and rd_addr_x == wr_addr, rd_data_x = wr_data in the same cycle. This applies per port.
  - When clr=1 there is no bypass and reads show stored contents.
- Bypass with BYPASS=0: reads show pre-edge contents until the edge commits the write.
- All register entries are general purpose; index 0 is not hardwired to zero.
- No X propagation: every read mux select value 0..7 is decoded explicitly.

Test Plan:
- Reset: assert reset mid-cycle with registers preloaded to nonzero values -> rd_data_a = rd_data_b = 0, written = 8'h00, wr_count = 0 immediately, before any clock edge.
- Write/read all: write 32'h1000_0000+i to register i for i = 0..7, then read each via port A and the reverse index via port B -> values match; written = 8'hFF; wr_count = 8.
- Latency with BYPASS=0: in cycle t, wr_en=1, wr_addr=3, wr_data=32'hDEAD_BEEF, rd_addr_a=3 -> rd_data_a keeps the old value in cycle t and reads 32'hDEAD_BEEF from cycle t+1.
- Bypass with BYPASS=1: same stimulus -> rd_data_a = 32'hDEAD_BEEF during cycle t; port B on rd_addr_b=4 is unaffected.
- Clear priority: clr=1 and wr_en=1 (wr_addr=5, wr_data=32'h1234_5678) on the same edge -> reg5 = 0, written = 0, wr_count = 0.
- Saturation: perform 20 consecutive writes to register 7 -> wr_count = 15; reg7 holds the last data; written = 8'h80.
